// File: rtl/input_mem_pkg.sv
// Shared types and default sizes for the input-memory RAM sequencer.
package input_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    localparam int DEF_ADD_SIZE  = 12;
    localparam int DEF_DATA_SIZE = 108;

endpackage

// File: rtl/input_ram_out_fifo.sv
// Small synchronous FIFO buffering RAM read data (plus last tag) toward the compute engine.
module input_ram_out_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 109
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_push,
    input  logic [W-1:0]                 i_data,
    input  logic                         i_pop,
    output logic [W-1:0]                 o_data,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wp] <= i_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (i_push) r_wp <= r_wp + 1'b1;
            if (i_pop)  r_rp <= r_rp + 1'b1;
            r_cnt <= r_cnt + CW'(i_push) - CW'(i_pop);
        end
    end

    // Data forced to zero while empty so the stream outputs read 0 out of reset.
    assign o_empty = (r_cnt == '0);
    assign o_count = r_cnt;
    assign o_data  = o_empty ? '0 : r_mem[r_rp];

endmodule

// File: rtl/input_ram_seq_ctrl.sv
// Input-memory sequencer: loads one frame into RAM, then replays it num_passes times
// through a credit-controlled output FIFO.
module input_ram_seq_ctrl
    import input_mem_pkg::*;
#(
    parameter int ADD_SIZE  = DEF_ADD_SIZE,
    parameter int DATA_SIZE = DEF_DATA_SIZE,
    parameter int PASS_W    = 4,
    parameter int OUT_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [ADD_SIZE:0]     i_frame_len,
    input  logic [PASS_W-1:0]     i_num_passes,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_start_err,
    input  logic                  i_s_valid,
    output logic                  o_s_ready,
    input  logic [DATA_SIZE-1:0]  i_s_data,
    output logic                  o_m_valid,
    input  logic                  i_m_ready,
    output logic [DATA_SIZE-1:0]  o_m_data,
    output logic                  o_m_last,
    output logic                  o_ram_write_en,
    output logic [ADD_SIZE-1:0]   o_ram_write_address,
    output logic [DATA_SIZE-1:0]  o_ram_data_in,
    output logic                  o_ram_read_en,
    output logic [ADD_SIZE-1:0]   o_ram_read_address,
    input  logic [DATA_SIZE-1:0]  i_ram_data_out,
    input  logic                  i_ram_out_valid
);
    localparam int CW = $clog2(OUT_DEPTH+1);
    localparam logic [ADD_SIZE:0] MAX_LEN = {1'b1, {ADD_SIZE{1'b0}}};

    state_t                r_state,  w_state_nxt;
    logic [ADD_SIZE:0]     r_len,    w_len_nxt;
    logic [PASS_W-1:0]     r_npass,  w_npass_nxt;
    logic [PASS_W-1:0]     r_pass,   w_pass_nxt;
    logic [ADD_SIZE-1:0]   r_wr_ptr, w_wr_nxt;
    logic [ADD_SIZE-1:0]   r_rd_ptr, w_rd_nxt;
    logic [ADD_SIZE-1:0]   r_ret_ptr, w_ret_nxt;
    logic [CW-1:0]         r_outstanding, w_out_nxt;
    logic                  r_busy,   w_busy_nxt;
    logic                  r_done,   w_done_nxt;
    logic                  r_err,    w_err_nxt;
    logic                  r_s_ready, w_sready_nxt;
    logic                  r_wen,    w_wen_nxt;
    logic [ADD_SIZE-1:0]   r_waddr,  w_waddr_nxt;
    logic [DATA_SIZE-1:0]  r_wdata,  w_wdata_nxt;
    logic                  r_ren;
    logic [ADD_SIZE-1:0]   r_raddr,  w_raddr_nxt;

    logic                  w_issue;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_empty;
    logic [CW-1:0]         w_fifo_cnt;
    logic [CW:0]           w_inflight;
    logic                  w_credit;
    logic                  w_wr_last;
    logic                  w_rd_last;
    logic                  w_ret_last;
    logic                  w_pass_last;
    logic [DATA_SIZE:0]    w_fifo_dout;

    // Returns are in issue order, so the word's position in the pass is recounted on arrival;
    // this yields the same last tag that was decided when the read was issued.
    assign w_wr_last   = ({1'b0, r_wr_ptr}  == r_len - 1'b1);
    assign w_rd_last   = ({1'b0, r_rd_ptr}  == r_len - 1'b1);
    assign w_ret_last  = ({1'b0, r_ret_ptr} == r_len - 1'b1);
    assign w_pass_last = (r_pass == r_npass - 1'b1);

    // Stale returns (e.g. after an abort) are dropped: only accepted while reads are owed.
    assign w_push = i_ram_out_valid && (r_outstanding != '0) &&
                    (r_state == ST_DRAIN || r_state == ST_FLUSH);
    assign w_pop  = !w_empty && i_m_ready;

    // Pop-aware credit: slots in flight plus buffered never exceed the FIFO depth.
    assign w_inflight = {1'b0, r_outstanding} + {1'b0, w_fifo_cnt} - (CW+1)'(w_pop);
    assign w_credit   = (w_inflight < (CW+1)'(OUT_DEPTH));

    always_comb begin
        w_state_nxt  = r_state;
        w_len_nxt    = r_len;
        w_npass_nxt  = r_npass;
        w_pass_nxt   = r_pass;
        w_wr_nxt     = r_wr_ptr;
        w_rd_nxt     = r_rd_ptr;
        w_ret_nxt    = r_ret_ptr;
        w_busy_nxt   = r_busy;
        w_sready_nxt = r_s_ready;
        w_waddr_nxt  = r_waddr;
        w_wdata_nxt  = r_wdata;
        w_raddr_nxt  = r_raddr;
        w_done_nxt   = 1'b0;
        w_err_nxt    = 1'b0;
        w_wen_nxt    = 1'b0;
        w_issue      = 1'b0;

        if (w_push) w_ret_nxt = w_ret_last ? '0 : r_ret_ptr + 1'b1;

        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    if (i_frame_len == '0) begin
                        w_done_nxt = 1'b1;
                    end else if (i_frame_len > MAX_LEN) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_state_nxt  = ST_LOAD;
                        w_len_nxt    = i_frame_len;
                        w_npass_nxt  = (i_num_passes == '0) ? PASS_W'(1) : i_num_passes;
                        w_pass_nxt   = '0;
                        w_wr_nxt     = '0;
                        w_rd_nxt     = '0;
                        w_ret_nxt    = '0;
                        w_busy_nxt   = 1'b1;
                        w_sready_nxt = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                w_err_nxt = i_start;
                if (i_s_valid && r_s_ready) begin
                    w_wen_nxt   = 1'b1;
                    w_waddr_nxt = r_wr_ptr;
                    w_wdata_nxt = i_s_data;
                    w_wr_nxt    = r_wr_ptr + 1'b1;
                    if (w_wr_last) begin
                        w_sready_nxt = 1'b0;
                        w_state_nxt  = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                w_err_nxt = i_start;
                if (w_credit) begin
                    w_issue     = 1'b1;
                    w_raddr_nxt = r_rd_ptr;
                    if (w_rd_last) begin
                        w_rd_nxt = '0;
                        if (w_pass_last) w_state_nxt = ST_FLUSH;
                        else             w_pass_nxt  = r_pass + 1'b1;
                    end else begin
                        w_rd_nxt = r_rd_ptr + 1'b1;
                    end
                end
            end
            ST_FLUSH: begin
                w_err_nxt = i_start;
                if (r_outstanding == '0 && w_empty) begin
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        w_out_nxt = r_outstanding + CW'(w_issue) - CW'(w_push);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_len         <= '0;
            r_npass       <= '0;
            r_pass        <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_ret_ptr     <= '0;
            r_outstanding <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_s_ready     <= 1'b0;
            r_wen         <= 1'b0;
            r_waddr       <= '0;
            r_wdata       <= '0;
            r_ren         <= 1'b0;
            r_raddr       <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_len         <= w_len_nxt;
            r_npass       <= w_npass_nxt;
            r_pass        <= w_pass_nxt;
            r_wr_ptr      <= w_wr_nxt;
            r_rd_ptr      <= w_rd_nxt;
            r_ret_ptr     <= w_ret_nxt;
            r_outstanding <= w_out_nxt;
            r_busy        <= w_busy_nxt;
            r_done        <= w_done_nxt;
            r_err         <= w_err_nxt;
            r_s_ready     <= w_sready_nxt;
            r_wen         <= w_wen_nxt;
            r_waddr       <= w_waddr_nxt;
            r_wdata       <= w_wdata_nxt;
            r_ren         <= w_issue;
            r_raddr       <= w_raddr_nxt;
        end
    end

    input_ram_out_fifo #(
        .DEPTH (OUT_DEPTH),
        .W     (DATA_SIZE+1)
    ) u_out_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  ({w_ret_last, i_ram_data_out}),
        .i_pop   (w_pop),
        .o_data  (w_fifo_dout),
        .o_empty (w_empty),
        .o_count (w_fifo_cnt)
    );

    assign o_busy              = r_busy;
    assign o_done              = r_done;
    assign o_start_err         = r_err;
    assign o_s_ready           = r_s_ready;
    assign o_m_valid           = !w_empty;
    assign o_m_data            = w_fifo_dout[DATA_SIZE-1:0];
    assign o_m_last            = w_fifo_dout[DATA_SIZE];
    assign o_ram_write_en      = r_wen;
    assign o_ram_write_address = r_waddr;
    assign o_ram_data_in       = r_wdata;
    assign o_ram_read_en       = r_ren;
    assign o_ram_read_address  = r_raddr;

endmodule
